// File: rtl/hazard_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } hz_state_t;

   localparam logic [1:0]  FWD_RF    = 2'b00;
   localparam logic [1:0]  FWD_EX    = 2'b01;
   localparam logic [1:0]  FWD_MEM   = 2'b10;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Width-parameterized saturating up-counter with asynchronous reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, stalls, flushes,
// DM wait-state freeze, halt drain and saturating perf counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW       = 4,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_is_hlt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic              ex_branch_taken,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              exmem_hold,
   output logic              memwb_bubble,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

   hz_state_t   state;
   logic [DW-1:0] drain_cnt;

   logic ex_a, ex_b, mem_a, mem_b;
   logic freeze, load_use, branch;
   logic stall_inc, flush_inc;

   function automatic logic src_match(input logic [REG_AW-1:0] src, input logic used,
                                      input logic [REG_AW-1:0] dst, input logic we);
      return used && we && (dst == src) && (dst != '0);
   endfunction

   always_comb begin
      ex_a     = src_match(id_rs, id_rs_used, ex_rd, ex_we);
      ex_b     = src_match(id_rt, id_rt_used, ex_rd, ex_we);
      mem_a    = src_match(id_rs, id_rs_used, mem_rd, mem_we);
      mem_b    = src_match(id_rt, id_rt_used, mem_rd, mem_we);
      freeze   = mem_req && !mem_ready;
      load_use = ex_is_load && (ex_a || ex_b);
      branch   = ex_branch_taken && (state != ST_HALTED);
   end

   always_comb begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_hold   = 1'b0;
      memwb_bubble = 1'b0;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
      if (!rst) begin
         fwd_a = (ex_a && !ex_is_load) ? FWD_EX : (mem_a ? FWD_MEM : FWD_RF);
         fwd_b = (ex_b && !ex_is_load) ? FWD_EX : (mem_b ? FWD_MEM : FWD_RF);
         if (freeze) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
         end else if (state == ST_HALTED) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
         end else if (branch) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if ((state == ST_DRAIN) || load_use || id_is_hlt) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
         end
      end
   end

   assign halted = (state == ST_HALTED);

   // A frozen cycle neither advances the drain nor consumes a pending branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
      end else if (!freeze) begin
         unique case (state)
            ST_RUN: begin
               if (!branch && !load_use && id_is_hlt) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DW'(1);
               end
            end
            ST_DRAIN: begin
               if (branch) begin
                  state     <= ST_RUN;
                  drain_cnt <= '0;
               end else if (drain_cnt == DW'(DRAIN_CYCLES)) begin
                  state <= ST_HALTED;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_inc = pc_hold && (state != ST_HALTED);
   assign flush_inc = branch && !freeze;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed steps plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

   localparam int DRAIN = 3;
   localparam int CW    = 16;
   localparam int MAXC  = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_rs_used, id_rt_used, id_is_hlt;
   logic       ex_we, ex_is_load, ex_branch_taken;
   logic       mem_we, mem_req, mem_ready;
   logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble;
   logic [1:0] fwd_a, fwd_b;
   logic       halted;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.REG_AW(4), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_is_hlt(id_is_hlt),
      .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Model: mode 0 running, 1 draining, 2 halted; drain_left counts remaining bubbles.
   int m_mode, m_left, m_stall, m_flush;
   logic e_pc, e_ifh, e_ifl, e_bub, e_exh, e_mwb;
   logic [1:0] e_fa, e_fb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic ex_hit(input logic [3:0] src, input logic used);
      return used && src != 0 && ex_we && ex_rd == src;
   endfunction

   function automatic logic mem_hit(input logic [3:0] src, input logic used);
      return used && src != 0 && mem_we && mem_rd == src;
   endfunction

   function automatic logic [1:0] fwd_ref(input logic [3:0] src, input logic used);
      if (ex_hit(src, used) && !ex_is_load) return 2'b01;
      if (mem_hit(src, used)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic predict();
      logic fz, lu, hold3;
      fz = mem_req && !mem_ready;
      lu = ex_is_load && (ex_hit(id_rs, id_rs_used) || ex_hit(id_rt, id_rt_used));
      e_fa = fwd_ref(id_rs, id_rs_used);
      e_fb = fwd_ref(id_rt, id_rt_used);
      {e_pc, e_ifh, e_ifl, e_bub, e_exh, e_mwb} = '0;
      hold3 = 1'b0;
      if (fz) {e_pc, e_ifh, e_exh, e_mwb} = 4'b1111;
      else if (m_mode == 2) hold3 = 1'b1;
      else if (ex_branch_taken) {e_ifl, e_bub} = 2'b11;
      else if (m_mode == 1 || lu || id_is_hlt) hold3 = 1'b1;
      if (hold3) {e_pc, e_ifh, e_bub} = 3'b111;
   endtask

   task automatic check_all();
      predict();
      chk("pc_hold", pc_hold, e_pc);
      chk("ifid_hold", ifid_hold, e_ifh);
      chk("ifid_flush", ifid_flush, e_ifl);
      chk("idex_bubble", idex_bubble, e_bub);
      chk("exmem_hold", exmem_hold, e_exh);
      chk("memwb_bubble", memwb_bubble, e_mwb);
      chk("fwd_a", fwd_a, e_fa);
      chk("fwd_b", fwd_b, e_fb);
      chk("halted", halted, m_mode == 2);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
   endtask

   task automatic model_clock();
      logic fz, lu;
      fz = mem_req && !mem_ready;
      lu = ex_is_load && (ex_hit(id_rs, id_rs_used) || ex_hit(id_rt, id_rt_used));
      if (e_pc && m_mode != 2 && m_stall < MAXC) m_stall++;
      if (!fz && m_mode != 2) begin
         if (ex_branch_taken) begin
            if (m_flush < MAXC) m_flush++;
            m_mode = 0;
         end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
         end else if (id_is_hlt && !lu) begin
            m_mode = 1;
            m_left = DRAIN;
         end
      end
   endtask

   // Called just after a posedge; checks mid-cycle and advances one clock.
   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle();
      {id_rs, id_rt, ex_rd, mem_rd} = '0;
      {id_rs_used, id_rt_used, id_is_hlt, ex_we, ex_is_load, ex_branch_taken} = '0;
      {mem_we, mem_req, mem_ready} = '0;
   endtask

   task automatic randomize_inputs();
      id_rs = 4'($urandom_range(0, 3));
      id_rt = 4'($urandom_range(0, 3));
      ex_rd = 4'($urandom_range(0, 3));
      mem_rd = 4'($urandom_range(0, 3));
      id_rs_used = 1'($urandom);
      id_rt_used = 1'($urandom);
      ex_we = 1'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0);
      mem_we = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      id_is_hlt = ($urandom_range(0, 19) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble}, 0);
      chk({tag, "_fwd"}, {fwd_a, fwd_b}, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_stall"}, stall_cnt, 0);
      chk({tag, "_flush"}, flush_cnt, 0);
   endtask

   task automatic do_reset();
      randomize_inputs();
      id_rs = 4'd1; id_rs_used = 1'b1; ex_rd = 4'd1; ex_we = 1'b1; ex_branch_taken = 1'b1;
      rst = 1'b1;
      #1;
      check_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
      idle();
   endtask

   int halted_run;
   int s0;

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // EX forwarding with priority over MEM
      id_rs = 4'd1; id_rs_used = 1'b1; ex_rd = 4'd1; ex_we = 1'b1;
      #1 chk("fwd_ex", fwd_a, 2'b01);
      step();
      mem_rd = 4'd1; mem_we = 1'b1;
      #1 chk("fwd_ex_over_mem", fwd_a, 2'b01);
      chk("fwd_ex_nostall", pc_hold, 0);
      step();

      // load-use then MEM forward
      idle();
      ex_rd = 4'd2; ex_we = 1'b1; ex_is_load = 1'b1; id_rt = 4'd2; id_rt_used = 1'b1;
      #1 chk("lu_stall", {pc_hold, ifid_hold, idex_bubble}, 3'b111);
      step();
      idle();
      mem_rd = 4'd2; mem_we = 1'b1; id_rt = 4'd2; id_rt_used = 1'b1;
      #1 chk("lu_fwd_mem", fwd_b, 2'b10);
      chk("lu_stall_cnt", stall_cnt, 1);
      chk("lu_one_cycle", pc_hold, 0);
      step();
      idle();
      ex_rd = 4'd0; ex_we = 1'b1; ex_is_load = 1'b1; id_rs = 4'd0; id_rs_used = 1'b1;
      #1 chk("lu_r0_nostall", pc_hold, 0);
      step();

      // branch overrides load-use
      idle();
      ex_rd = 4'd3; ex_we = 1'b1; ex_is_load = 1'b1; id_rs = 4'd3; id_rs_used = 1'b1;
      ex_branch_taken = 1'b1;
      #1 chk("br_ctl", {ifid_flush, idex_bubble, pc_hold}, 3'b110);
      step();
      chk("br_flush_cnt", flush_cnt, 1);

      // freeze with a pending branch, then release
      idle();
      s0 = int'(stall_cnt);
      ex_branch_taken = 1'b1; mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("frz_ctl", {pc_hold, ifid_hold, exmem_hold, memwb_bubble, ifid_flush, idex_bubble}, 6'b111100);
         step();
      end
      chk("frz_stall_cnt", stall_cnt - 16'(s0), 3);
      chk("frz_no_flush", flush_cnt, 1);
      mem_ready = 1'b1;
      #1 chk("frz_release_flush", ifid_flush, 1);
      step();
      chk("frz_flush_cnt", flush_cnt, 2);

      // halt drain timing
      idle();
      id_is_hlt = 1'b1;
      step();
      idle();
      for (int c = 1; c <= 6; c++) begin
         chk("halt_timing", halted, c > DRAIN);
         if (c == 5) ex_branch_taken = 1'b1;
         step();
         idle();
      end
      chk("halt_sticky", halted, 1);

      // branch squashes HLT in second drain cycle
      do_reset();
      id_is_hlt = 1'b1;
      step();
      idle();
      step();
      ex_branch_taken = 1'b1;
      step();
      idle();
      for (int c = 0; c < 6; c++) begin
         chk("squash_no_halt", halted, 0);
         step();
      end

      // randomized traffic
      do_reset();
      halted_run = 0;
      for (int n = 0; n < 800; n++) begin
         randomize_inputs();
         step();
         if (m_mode == 2) halted_run++;
         if (halted_run > 3) begin
            do_reset();
            halted_run = 0;
         end
      end

      // stall counter saturation
      do_reset();
      mem_req = 1'b1;
      for (int n = 0; n < MAXC - 1; n++) step();
      chk("sat_fffe", stall_cnt, 16'hFFFE);
      for (int n = 0; n < 3; n++) step();
      chk("sat_ffff", stall_cnt, 16'hFFFF);

      // reset asserted mid-drain
      do_reset();
      ex_branch_taken = 1'b1;
      step();
      idle();
      id_is_hlt = 1'b1;
      step();
      idle();
      step();
      ex_rd = 4'd1; ex_we = 1'b1; id_rs = 4'd1; id_rs_used = 1'b1; mem_req = 1'b1;
      #2 rst = 1'b1;
      #1 check_zero("mid_drain_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
      idle();
      step();
      chk("post_rst_run", halted, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage 16-bit core (IF/ID/EX/MEM/WB).
- Generates PC hold, per-stage-register hold/bubble/flush controls and ID-stage operand forwarding selects from decoded register fields of the ID, EX and MEM stages.
- Sequences halt drain and freezes the pipe during data-memory wait states.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_AW, 4, register address width (16-entry RF; r0 hardwired zero)
DRAIN_CYCLES, 3, cycles of bubble insertion after HLT decode before halted asserts
CNT_W, 16, perf counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_rs  in  REG_AW  ID source A register
id_rt  in  REG_AW  ID source B register
id_rs_used  in  1  ID instr reads rs
id_rt_used  in  1  ID instr reads rt
id_is_hlt  in  1  ID instr is HLT
ex_rd  in  REG_AW  EX destination register
ex_we  in  1  EX instr writes RF
ex_is_load  in  1  EX instr is a load
ex_branch_taken  in  1  EX resolved taken branch/jump
mem_rd  in  REG_AW  MEM destination register
mem_we  in  1  MEM instr writes RF
mem_req  in  1  MEM stage accessing DM
mem_ready  in  1  DM access completes this cycle
pc_hold  out  1  PC keeps value
ifid_hold  out  1  IF/ID keeps value
ifid_flush  out  1  IF/ID loads NOP (0x0000)
idex_bubble  out  1  ID/EX loads NOP
exmem_hold  out  1  EX/MEM and ID/EX keep value
memwb_bubble  out  1  MEM/WB loads NOP (we=0)
fwd_a  out  2  rs select: 00 RF, 01 EX result, 10 MEM writeback value
fwd_b  out  2  rt select, same encoding
halted  out  1  core halted
stall_cnt  out  CNT_W  cycles with pc_hold=1 outside HALTED
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Reset: state RUN, drain counter 0, stall_cnt=0, flush_cnt=0. All outputs 0 while rst high.
- Match rule: src matches dst iff src_used && dst_we && dst==src && dst!=0.
- Forwarding (combinational, all states):
  - fwd_x=01 if EX matches and !ex_is_load; else 10 if MEM matches; else 00.
  - EX has priority over MEM.
- Control outputs are combinational from state and inputs, in priority order:
  1. Freeze (mem_req && !mem_ready): pc_hold, ifid_hold, exmem_hold, memwb_bubble = 1. Flush and bubble outputs are forced to 0; a pending branch stays in EX and flushes on the release cycle. State and drain counter do not advance.
  2. Branch (ex_branch_taken): ifid_flush=1, idex_bubble=1, pc_hold=0. flush_cnt increments. Overrides load-use and halt; from DRAIN, return to RUN (the HLT is squashed) and clear the drain counter.
  3. Load-use: ex_is_load and EX matches rs or rt. pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle. The next cycle forwards via 10.
  4. HLT in RUN: same outputs as load-use; next state DRAIN, counter=1.
- States:
  - RUN: normal operation.
  - DRAIN: pc_hold, ifid_hold, idex_bubble = 1. Counter increments each unfrozen cycle; at counter==DRAIN_CYCLES, next state HALTED.
  - HALTED: halted=1, pc_hold=1, ifid_hold=1, idex_bubble=1, ex_branch_taken ignored. Only rst exits.
- Counters:
  - stall_cnt +1 per cycle with pc_hold=1 and state!=HALTED.
  - flush_cnt +1 per unfrozen branch cycle.
  - Both saturate at all-ones; no wrap.
- Reset mid-freeze or mid-drain returns immediately to RUN with counters cleared.
- Latency: all controls are same-cycle; state updates on posedge clk.

Decomposition:
- hazard_pkg: state encoding (RUN, DRAIN, HALTED), FWD_RF/FWD_EX/FWD_MEM constants, NOP encoding 0x0000.
- Sub-module sat_counter: width-parameterized saturating counter with async reset; instantiated twice (stall_cnt, flush_cnt).

Test Plan:
- ADD r1 in EX (ex_rd=1, ex_we=1), ID reads rs=1 -> fwd_a=01, no stall. Same with mem_rd=1 also matching -> fwd_a still 01.
- Load r2 in EX, ID rt=2 used -> one cycle pc_hold=ifid_hold=idex_bubble=1. Next cycle (load in MEM) -> fwd_b=10, stall_cnt=1. ex_rd=0 load -> no stall.
- ex_branch_taken with load-use present -> ifid_flush=idex_bubble=1, pc_hold=0, flush_cnt=1.
- mem_req=1, mem_ready=0 for 3 cycles while ex_branch_taken=1 -> freeze outputs for 3 cycles, no flush. Flush asserts on the mem_ready cycle; stall_cnt=3, flush_cnt=1.
- id_is_hlt -> DRAIN; halted asserts exactly DRAIN_CYCLES+1 cycles after HLT decode and stays 1. Branch in second drain cycle -> back to RUN, halted never asserts.
- Force stall_cnt to 0xFFFE, hold 3 stall cycles -> reads 0xFFFF. Assert rst mid-DRAIN -> all outputs 0, counters 0.
